pipeline_ctrl: RTL

Hazard and sequencing controller for the 5-stage RV32IM pipeline (IF/ID/EX/MEM/WB). It takes register-use and control information from the decode stage plus branch resolution from execute. It drives the stall, bubble and flush enables of the pipeline registers. It also sequences the multi-cycle mul/div unit and keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_ctrl_if.sv | 47 ++++
 rtl/pipeline_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// Bundle of decode/execute hazard inputs and pipeline-register control outputs
// exchanged between the RV32IM datapath (master) and pipeline_ctrl (slave).
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    // Decode-stage view
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             id_muldiv;

    // Execute-stage view
    logic             ex_valid;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             ex_branch_taken;

    logic             cnt_clr;

    // Pipeline-register enables and sequencing
    logic             stall_if;
    logic             stall_id;
    logic             hold_ex;
    logic             bubble_ex;
    logic             bubble_mem;
    logic             flush_id;
    logic             pc_redirect;
    logic             muldiv_start;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_muldiv,
        output ex_valid, ex_mem_read, ex_rd, ex_branch_taken, cnt_clr,
        input  stall_if, stall_id, hold_ex, bubble_ex, bubble_mem, flush_id,
        input  pc_redirect, muldiv_start, md_busy, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_muldiv,
        input  ex_valid, ex_mem_read, ex_rd, ex_branch_taken, cnt_clr,
        output stall_if, stall_id, hold_ex, bubble_ex, bubble_mem, flush_id,
        output pc_redirect, muldiv_start, md_busy, stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32IM pipeline: load-use
// stalls, taken-branch flushes, multi-cycle mul/div occupancy and a stall counter.
module pipeline_ctrl #(
    parameter int MULDIV_LATENCY = 4,
    parameter int CNT_W          = 16
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave ctl
);

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic hold_ex;
        logic bubble_ex;
        logic bubble_mem;
        logic flush_id;
        logic pc_redirect;
        logic muldiv_start;
        logic md_busy;
    } ctrl_t;

    localparam logic [4:0] MD_RELOAD = 5'(MULDIV_LATENCY - 1);
    localparam bit         MD_MULTI  = (MULDIV_LATENCY > 1);

    state_e           state_q, state_d;
    logic [4:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic  rs1_hit;
    logic  rs2_hit;
    logic  load_use;
    ctrl_t ctrl_raw;
    ctrl_t ctrl_out;

    // x0 is hard-wired to zero, so a load targeting it can never feed a consumer.
    always_comb begin
        rs1_hit  = ctl.id_use_rs1 && (ctl.id_rs1 == ctl.ex_rd);
        rs2_hit  = ctl.id_use_rs2 && (ctl.id_rs2 == ctl.ex_rd);
        load_use = ctl.ex_valid && ctl.ex_mem_read && (ctl.ex_rd != 5'd0)
                   && ctl.id_valid && (rs1_hit || rs2_hit);
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        ctrl_raw = '0;
        state_d  = state_q;
        md_cnt_d = md_cnt_q;

        unique case (state_q)
            IDLE: begin
                // A taken branch kills the younger instructions, so any hazard is moot.
                if (ctl.ex_branch_taken) begin
                    ctrl_raw.pc_redirect = 1'b1;
                    ctrl_raw.flush_id    = 1'b1;
                    ctrl_raw.bubble_ex   = 1'b1;
                end else if (load_use) begin
                    ctrl_raw.stall_if  = 1'b1;
                    ctrl_raw.stall_id  = 1'b1;
                    ctrl_raw.bubble_ex = 1'b1;
                end else if (ctl.id_valid && ctl.id_muldiv) begin
                    ctrl_raw.muldiv_start = 1'b1;
                    if (MD_MULTI) begin
                        state_d  = MD_BUSY;
                        md_cnt_d = MD_RELOAD;
                    end
                end
            end

            MD_BUSY: begin
                ctrl_raw.stall_if   = 1'b1;
                ctrl_raw.stall_id   = 1'b1;
                ctrl_raw.hold_ex    = 1'b1;
                ctrl_raw.bubble_mem = 1'b1;
                ctrl_raw.md_busy    = 1'b1;
                md_cnt_d            = md_cnt_q - 5'd1;
                if (md_cnt_q <= 5'd1) begin
                    state_d  = IDLE;
                    md_cnt_d = 5'd0;
                end
            end

            default: begin
                state_d  = IDLE;
                md_cnt_d = 5'd0;
            end
        endcase
    end

    // Outputs are forced low for the whole reset window, not just after the edge.
    always_comb begin
        ctrl_out = rst ? '0 : ctrl_raw;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ctl.cnt_clr) begin
            stall_cnt_d = '0;
        end else if (ctrl_out.stall_id && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            md_cnt_q    <= 5'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ctl.stall_if     = ctrl_out.stall_if;
    assign ctl.stall_id     = ctrl_out.stall_id;
    assign ctl.hold_ex      = ctrl_out.hold_ex;
    assign ctl.bubble_ex    = ctrl_out.bubble_ex;
    assign ctl.bubble_mem   = ctrl_out.bubble_mem;
    assign ctl.flush_id     = ctrl_out.flush_id;
    assign ctl.pc_redirect  = ctrl_out.pc_redirect;
    assign ctl.muldiv_start = ctrl_out.muldiv_start;
    assign ctl.md_busy      = ctrl_out.md_busy;
    assign ctl.stall_cycles = stall_cnt_q;

endmodule
